lsb_queue: RTL and testbench

LSB_QUEUE -- requirements
Module: lsb_queue

---
 rtl/lsb_queue_pkg.sv | 35 +++
 rtl/lsb_entry.sv | 59 +++++
 rtl/lsb_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_queue_pkg.sv
// Shared definitions for the load/store queue: tag width, memory opcodes,
// the per-entry record and small opcode helpers.
package lsb_queue_pkg;

  localparam int TAG_W = 5;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  // One queued memory instruction with its operand readiness and commit mark.
  typedef struct packed {
    logic             valid;
    logic             committed;
    logic [TAG_W-1:0] ins_id;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic [31:0]      rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_rdy;
    logic [31:0]      rs2_val;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_rdy;
  } lsb_entry_t;

  function automatic logic is_load(input logic [6:0] op);
    return op == LOAD;
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    return op == STORE;
  endfunction

endpackage

// File: rtl/lsb_entry.sv
// Single load/store queue slot: holds the entry record, captures operands
// from the result broadcast (including on the cycle it is written) and marks
// a store committed when the ROB commits its tag.
module lsb_entry
  import lsb_queue_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             wr_en,
  input  lsb_entry_t       wr_data,
  input  logic             clr_en,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_id,
  input  logic [31:0]      cdb_val,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_id,
  output lsb_entry_t       ent
);

  lsb_entry_t nxt;

  // Next entry value: write, then broadcast capture / commit mark, clear wins.
  always_comb begin
    nxt = ent;
    if (wr_en) begin
      nxt           = wr_data;
      nxt.valid     = 1'b1;
      nxt.committed = 1'b0;
    end
    if (nxt.valid) begin
      if (cdb_valid && !nxt.rs1_rdy && (nxt.rs1_tag == cdb_id)) begin
        nxt.rs1_val = cdb_val;
        nxt.rs1_rdy = 1'b1;
      end
      if (cdb_valid && !nxt.rs2_rdy && (nxt.rs2_tag == cdb_id)) begin
        nxt.rs2_val = cdb_val;
        nxt.rs2_rdy = 1'b1;
      end
      if (commit_valid && is_store(nxt.opcode) && (nxt.ins_id == commit_id)) begin
        nxt.committed = 1'b1;
      end
    end
    if (clr_en) begin
      nxt.valid     = 1'b0;
      nxt.committed = 1'b0;
    end
  end

  // Entry storage; frozen while the global ready is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ent <= '0;
    end else if (rdy_in) begin
      ent <= nxt;
    end
  end

endmodule

// File: rtl/lsb_queue.sv
// Load/store queue: circular buffer of memory instructions issued in order
// from the head to the memory operator.
// Optional feature macro: LSB_STATS_EN adds stall_cnt / issue_cnt outputs.
//
// Handshakes: an enqueue is accepted on a cycle with enq_valid=1 while the
// registered full=0 (and no flush); enq_valid while full is dropped, not
// held. The issue port has no ready: have_ins is a one-cycle pulse, and the
// entry stays busy at the head until mem_done arrives with its ins_id.
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 enq_valid,
  input  logic [TAG_W-1:0]     enq_ins_id,
  input  logic [6:0]           enq_opcode,
  input  logic [2:0]           enq_funct3,
  input  logic [6:0]           enq_funct7,
  input  logic [31:0]          enq_imm,
  input  logic [31:0]          enq_rs1_val,
  input  logic [31:0]          enq_rs2_val,
  input  logic [TAG_W-1:0]     enq_rs1_tag,
  input  logic [TAG_W-1:0]     enq_rs2_tag,
  input  logic                 enq_rs1_rdy,
  input  logic                 enq_rs2_rdy,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_id,
  input  logic [31:0]          cdb_val,
  input  logic                 commit_valid,
  input  logic [TAG_W-1:0]     commit_id,
  input  logic                 flush,
  output logic                 have_ins,
  output logic [TAG_W-1:0]     ins_id,
  output logic [31:0]          addr,
  output logic [31:0]          data,
  output logic [6:0]           opcode,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  input  logic                 mem_done,
  input  logic [TAG_W-1:0]     mem_done_id,
  output logic [$clog2(DEPTH):0] dbg_count,
  output logic                 dbg_busy,
  output logic                 dbg_drop,
  output lsb_entry_t           dbg_head
`ifdef LSB_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          issue_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
  logic [CNT_W-1:0] count, count_nxt, prefix;
  logic             busy, drop, have_ins_q;
  logic [TAG_W-1:0] drop_id;
  logic [DEPTH-1:0] keep, wr_en, clr_en;
  lsb_entry_t       ents [DEPTH];
  lsb_entry_t       head_ent, enq_ent;
  logic             enq_acc, pop, drop_done, issue, head_ok;
  logic             cdb_g, commit_g;

  assign head_ent  = ents[head];
  assign enq_acc   = enq_valid && !full && !flush;
  assign pop       = busy && mem_done && (mem_done_id == head_ent.ins_id);
  assign drop_done = drop && mem_done && (mem_done_id == drop_id);
  assign cdb_g     = cdb_valid && !flush;
  assign commit_g  = commit_valid && !flush;

  // Head may issue only when idle, no dropped load outstanding, and operands ready.
  assign head_ok = (count != '0) && head_ent.valid && !busy && !drop && head_ent.rs1_rdy &&
                   (is_load(head_ent.opcode) ||
                    (is_store(head_ent.opcode) && head_ent.rs2_rdy && head_ent.committed));
  assign issue   = head_ok && !flush;

  // Incoming entry record built from the dispatch fields.
  always_comb begin
    enq_ent           = '0;
    enq_ent.valid     = 1'b1;
    enq_ent.ins_id    = enq_ins_id;
    enq_ent.opcode    = enq_opcode;
    enq_ent.funct3    = enq_funct3;
    enq_ent.funct7    = enq_funct7;
    enq_ent.imm       = enq_imm;
    enq_ent.rs1_val   = enq_rs1_val;
    enq_ent.rs1_tag   = enq_rs1_tag;
    enq_ent.rs1_rdy   = enq_rs1_rdy;
    enq_ent.rs2_val   = enq_rs2_val;
    enq_ent.rs2_tag   = enq_rs2_tag;
    enq_ent.rs2_rdy   = enq_rs2_rdy;
  end

  // Committed-store run starting at the head: these entries survive a flush.
  always_comb begin
    logic             run;
    logic [PTR_W-1:0] idx;
    run    = 1'b1;
    idx    = '0;
    prefix = '0;
    keep   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (run && (CNT_W'(i) < count) && ents[idx].valid && ents[idx].committed &&
          is_store(ents[idx].opcode)) begin
        keep[idx] = 1'b1;
        prefix    = prefix + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Per-slot write and clear strobes.
  always_comb begin
    wr_en  = '0;
    clr_en = '0;
    for (int k = 0; k < DEPTH; k++) begin
      wr_en[k]  = enq_acc && (tail == PTR_W'(k));
      clr_en[k] = (pop && (head == PTR_W'(k))) || (flush && !keep[k]);
    end
  end

  // Pointer and occupancy update; a flush rebuilds tail from the kept prefix.
  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    if (flush) begin
      tail_nxt  = head + prefix[PTR_W-1:0];
      count_nxt = prefix;
      if (pop && keep[head]) begin
        head_nxt  = head + PTR_W'(1);
        count_nxt = prefix - CNT_W'(1);
      end
    end else begin
      if (enq_acc) tail_nxt = tail + PTR_W'(1);
      if (pop)     head_nxt = head + PTR_W'(1);
      count_nxt = count + CNT_W'(enq_acc) - CNT_W'(pop);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    lsb_entry u_entry (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .wr_en        (wr_en[k]),
      .wr_data      (enq_ent),
      .clr_en       (clr_en[k]),
      .cdb_valid    (cdb_g),
      .cdb_id       (cdb_id),
      .cdb_val      (cdb_val),
      .commit_valid (commit_g),
      .commit_id    (commit_id),
      .ent          (ents[k])
    );
  end

  // Queue control state and registered issue port.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      full       <= 1'b0;
      busy       <= 1'b0;
      drop       <= 1'b0;
      drop_id    <= '0;
      have_ins_q <= 1'b0;
      ins_id     <= '0;
      addr       <= '0;
      data       <= '0;
      opcode     <= '0;
      funct3     <= '0;
      funct7     <= '0;
    end else if (!rdy_in) begin
      have_ins_q <= 1'b0;
    end else begin
      head       <= head_nxt;
      tail       <= tail_nxt;
      count      <= count_nxt;
      full       <= (count_nxt == CNT_W'(DEPTH));
      have_ins_q <= issue;
      if (issue) begin
        ins_id <= head_ent.ins_id;
        addr   <= head_ent.rs1_val + head_ent.imm;
        data   <= is_store(head_ent.opcode) ? head_ent.rs2_val : 32'd0;
        opcode <= head_ent.opcode;
        funct3 <= head_ent.funct3;
        funct7 <= head_ent.funct7;
      end
      if (drop_done) drop <= 1'b0;
      if (pop) begin
        busy <= 1'b0;
      end else if (flush && busy && !keep[head]) begin
        // In-flight load discarded: remember its tag to swallow its completion.
        busy    <= 1'b0;
        drop    <= 1'b1;
        drop_id <= head_ent.ins_id;
      end else if (issue) begin
        busy <= 1'b1;
      end
    end
  end

  assign have_ins  = have_ins_q && rdy_in;
  assign dbg_count = count;
  assign dbg_busy  = busy;
  assign dbg_drop  = drop;
  assign dbg_head  = head_ent;

`ifdef LSB_STATS_EN
  // Wrapping activity counters; flush does not touch them.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else if (rdy_in) begin
      if (enq_valid && full) stall_cnt <= stall_cnt + 32'd1;
      if (issue)             issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsb_queue.sv
// Testbench for lsb_queue: directed scenarios with randomized operand values
// plus a randomized load stream checked against an in-order queue model.
module tb_lsb_queue;
  import lsb_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk_in, rst_in, rdy_in;
  logic        enq_valid;
  logic [4:0]  enq_ins_id;
  logic [6:0]  enq_opcode;
  logic [2:0]  enq_funct3;
  logic [6:0]  enq_funct7;
  logic [31:0] enq_imm, enq_rs1_val, enq_rs2_val;
  logic [4:0]  enq_rs1_tag, enq_rs2_tag;
  logic        enq_rs1_rdy, enq_rs2_rdy;
  logic        full;
  logic        cdb_valid;
  logic [4:0]  cdb_id;
  logic [31:0] cdb_val;
  logic        commit_valid;
  logic [4:0]  commit_id;
  logic        flush;
  logic        have_ins;
  logic [4:0]  ins_id;
  logic [31:0] addr, data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        mem_done;
  logic [4:0]  mem_done_id;
  logic [3:0]  dbg_count;
  logic        dbg_busy, dbg_drop;
  lsb_entry_t  dbg_head;
`ifdef LSB_STATS_EN
  logic [31:0] stall_cnt, issue_cnt;
`endif

  int checks = 0;
  int failures = 0;

  lsb_queue #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .enq_valid(enq_valid), .enq_ins_id(enq_ins_id), .enq_opcode(enq_opcode),
    .enq_funct3(enq_funct3), .enq_funct7(enq_funct7), .enq_imm(enq_imm),
    .enq_rs1_val(enq_rs1_val), .enq_rs2_val(enq_rs2_val),
    .enq_rs1_tag(enq_rs1_tag), .enq_rs2_tag(enq_rs2_tag),
    .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy), .full(full),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .commit_valid(commit_valid), .commit_id(commit_id), .flush(flush),
    .have_ins(have_ins), .ins_id(ins_id), .addr(addr), .data(data),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_done(mem_done), .mem_done_id(mem_done_id),
    .dbg_count(dbg_count), .dbg_busy(dbg_busy), .dbg_drop(dbg_drop), .dbg_head(dbg_head)
`ifdef LSB_STATS_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );

  // Clock and watchdog
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    enq_valid = 0; enq_ins_id = 0; enq_opcode = 0; enq_funct3 = 0; enq_funct7 = 0;
    enq_imm = 0; enq_rs1_val = 0; enq_rs2_val = 0; enq_rs1_tag = 0; enq_rs2_tag = 0;
    enq_rs1_rdy = 0; enq_rs2_rdy = 0;
    cdb_valid = 0; cdb_id = 0; cdb_val = 0;
    commit_valid = 0; commit_id = 0; flush = 0; mem_done = 0; mem_done_id = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rdy_in = 1;
    rst_in = 0;
    repeat (2) step();
    rst_in = 1;
    step();
  endtask

  task automatic set_enq(input logic [4:0] id, input logic [6:0] op, input logic [31:0] imm,
                         input logic r1, input logic [31:0] v1, input logic [4:0] t1,
                         input logic r2, input logic [31:0] v2, input logic [4:0] t2);
    enq_valid = 1; enq_ins_id = id; enq_opcode = op; enq_funct3 = 3'b010; enq_funct7 = 7'd0;
    enq_imm = imm; enq_rs1_rdy = r1; enq_rs1_val = v1; enq_rs1_tag = t1;
    enq_rs2_rdy = r2; enq_rs2_val = v2; enq_rs2_tag = t2;
  endtask

  task automatic wait_issue(input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      if (have_ins === 1'b1) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic done(input logic [4:0] id);
    mem_done = 1; mem_done_id = id;
    step();
    mem_done = 0;
  endtask

  // Scenarios
  task automatic test_reset();
    clear_inputs();
    rdy_in = 1;
    rst_in = 0;
    step(); step();
    checks++; if (have_ins !== 1'b0) begin failures++; $display("FAIL reset_have_ins got=%b exp=0", have_ins); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (addr !== 32'd0 || data !== 32'd0) begin failures++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", addr, data); end
    checks++; if (ins_id !== 5'd0 || opcode !== 7'd0) begin failures++; $display("FAIL reset_id_op got=%h/%h exp=0/0", ins_id, opcode); end
    checks++; if (dbg_count !== 4'd0 || dbg_busy !== 1'b0) begin failures++; $display("FAIL reset_count_busy got=%0d/%b exp=0/0", dbg_count, dbg_busy); end
    rst_in = 1;
    step();
  endtask

  task automatic test_load();
    logic [31:0] rs1, imm;
    logic [4:0]  id;
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      rs1 = (n == 0) ? 32'h1000 : $urandom;
      imm = (n == 0) ? 32'h10 : $urandom;
      id  = 5'(n + 1);
      set_enq(id, LOAD, imm, 1, rs1, 0, 0, 32'hFFFF, 0);
      step(); clear_inputs();
      checks++; if (have_ins !== 1'b0) begin failures++; $display("FAIL load_early got=%b exp=0", have_ins); end
      step();
      checks++; if (have_ins !== 1'b1) begin failures++; $display("FAIL load_issue got=%b exp=1", have_ins); end
      checks++; if (addr !== rs1 + imm) begin failures++; $display("FAIL load_addr got=%h exp=%h", addr, rs1 + imm); end
      checks++; if (data !== 32'd0 || ins_id !== id || opcode !== LOAD) begin failures++; $display("FAIL load_fields got=%h/%h/%h exp=0/%h/%h", data, ins_id, opcode, id, LOAD); end
      step();
      checks++; if (have_ins !== 1'b0) begin failures++; $display("FAIL load_pulse got=%b exp=0", have_ins); end
      done(id ^ 5'd8);
      checks++; if (dbg_count !== 4'd1) begin failures++; $display("FAIL load_wrong_done got=%0d exp=1", dbg_count); end
      done(id);
      checks++; if (dbg_count !== 4'd0 || dbg_busy !== 1'b0) begin failures++; $display("FAIL load_pop got=%0d/%b exp=0/0", dbg_count, dbg_busy); end
    end
  endtask

  task automatic test_store_commit();
    logic [31:0] rs1, imm;
    bit seen, ok;
    apply_reset();
    rs1 = $urandom; imm = $urandom_range(0, 4095);
    set_enq(5'd2, STORE, imm, 1, rs1, 0, 0, 0, 5'd7);
    step(); clear_inputs();
    cdb_valid = 1; cdb_id = 5'd7; cdb_val = 32'hAB;
    step(); clear_inputs();
    seen = 0;
    commit_valid = 1; commit_id = 5'd9;
    for (int n = 0; n < 4; n++) begin
      if (have_ins === 1'b1) seen = 1;
      step(); clear_inputs();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL store_no_commit got=%b exp=0", seen); end
    commit_valid = 1; commit_id = 5'd2;
    step(); clear_inputs();
    wait_issue(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL store_issue_timeout got=0 exp=1"); end
    checks++; if (data !== 32'hAB || addr !== rs1 + imm || ins_id !== 5'd2) begin failures++; $display("FAIL store_issue got=%h/%h/%h exp=ab/%h/02", data, addr, ins_id, rs1 + imm); end
    step();
    done(5'd2);
    checks++; if (dbg_count !== 4'd0) begin failures++; $display("FAIL store_pop got=%0d exp=0", dbg_count); end
  endtask

  task automatic test_full();
    bit ok;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(5'(i), LOAD, 32'(i * 4), (i == 0), 32'h100, 5'd31, 0, 0, 0);
      step();
    end
    clear_inputs();
    checks++; if (full !== 1'b1 || dbg_count !== 4'(DEPTH)) begin failures++; $display("FAIL full_set got=%b/%0d exp=1/%0d", full, dbg_count, DEPTH); end
    set_enq(5'd20, LOAD, 0, 1, 0, 0, 0, 0, 0);
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'(DEPTH)) begin failures++; $display("FAIL full_reject got=%0d exp=%0d", dbg_count, DEPTH); end
    set_enq(5'd21, LOAD, 0, 1, 0, 0, 0, 0, 0);
    mem_done = 1; mem_done_id = 5'd0;
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'(DEPTH - 1) || full !== 1'b0) begin failures++; $display("FAIL full_pop_reject got=%0d/%b exp=%0d/0", dbg_count, full, DEPTH - 1); end
    set_enq(5'd22, LOAD, 0, 1, 0, 0, 0, 0, 0);
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'(DEPTH) || full !== 1'b1) begin failures++; $display("FAIL full_refill got=%0d/%b exp=%0d/1", dbg_count, full, DEPTH); end
    cdb_valid = 1; cdb_id = 5'd31; cdb_val = 32'h200;
    step(); clear_inputs();
    wait_issue(5, ok);
    checks++; if (!ok || ins_id !== 5'd1 || addr !== 32'h204) begin failures++; $display("FAIL full_next_issue got=%b/%h/%h exp=1/01/00000204", ok, ins_id, addr); end
    step();
    done(5'd1);
    wait_issue(5, ok);
    checks++; if (!ok || ins_id !== 5'd2 || addr !== 32'h208) begin failures++; $display("FAIL full_issue2 got=%b/%h/%h exp=1/02/00000208", ok, ins_id, addr); end
    step();
    set_enq(5'd24, LOAD, 0, 1, 0, 0, 0, 0, 0);
    mem_done = 1; mem_done_id = 5'd2;
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'(DEPTH - 1)) begin failures++; $display("FAIL pop_enq_same got=%0d exp=%0d", dbg_count, DEPTH - 1); end
  endtask

  task automatic test_cdb_bypass();
    logic [31:0] imm;
    bit ok;
    apply_reset();
    imm = $urandom_range(0, 4095);
    set_enq(5'd9, LOAD, imm, 0, 0, 5'd3, 0, 0, 0);
    cdb_valid = 1; cdb_id = 5'd3; cdb_val = 32'h20;
    step(); clear_inputs();
    wait_issue(4, ok);
    checks++; if (!ok || addr !== 32'h20 + imm) begin failures++; $display("FAIL cdb_bypass got=%b/%h exp=1/%h", ok, addr, 32'h20 + imm); end
    step();
    done(5'd9);
  endtask

  task automatic test_flush();
    bit ok, seen;
    // committed store survives, loads behind it are discarded
    apply_reset();
    set_enq(5'd4, STORE, 32'h8, 0, 0, 5'd30, 1, 32'h55, 0); step();
    set_enq(5'd5, LOAD, 0, 1, 32'h40, 0, 0, 0, 0); step();
    set_enq(5'd6, LOAD, 0, 1, 32'h44, 0, 0, 0, 0); step();
    clear_inputs();
    commit_valid = 1; commit_id = 5'd4;
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", dbg_count); end
    flush = 1;
    set_enq(5'd7, LOAD, 0, 1, 0, 0, 0, 0, 0);
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'd1 || full !== 1'b0) begin failures++; $display("FAIL flush_keep_store got=%0d/%b exp=1/0", dbg_count, full); end
    cdb_valid = 1; cdb_id = 5'd30; cdb_val = 32'h3000;
    step(); clear_inputs();
    wait_issue(5, ok);
    checks++; if (!ok || ins_id !== 5'd4 || data !== 32'h55 || addr !== 32'h3008) begin failures++; $display("FAIL flush_store_issue got=%b/%h/%h/%h exp=1/04/55/3008", ok, ins_id, data, addr); end
    step();
    done(5'd4);
    checks++; if (dbg_count !== 4'd0) begin failures++; $display("FAIL flush_store_pop got=%0d exp=0", dbg_count); end
    // in-flight load discarded; its completion must not pop
    apply_reset();
    set_enq(5'd5, LOAD, 0, 1, 32'h40, 0, 0, 0, 0); step();
    set_enq(5'd6, LOAD, 0, 1, 32'h44, 0, 0, 0, 0); step();
    clear_inputs();
    wait_issue(5, ok);
    step();
    flush = 1;
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'd0 || dbg_drop !== 1'b1 || dbg_busy !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0d/%b/%b exp=0/1/0", dbg_count, dbg_drop, dbg_busy); end
    set_enq(5'd5, LOAD, 32'h8, 1, 32'h80, 0, 0, 0, 0);
    step(); clear_inputs();
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      if (have_ins === 1'b1) seen = 1;
      step();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL drop_hold got=%b exp=0", seen); end
    done(5'd5);
    checks++; if (dbg_count !== 4'd1 || dbg_drop !== 1'b0) begin failures++; $display("FAIL drop_no_pop got=%0d/%b exp=1/0", dbg_count, dbg_drop); end
    wait_issue(5, ok);
    checks++; if (!ok || addr !== 32'h88) begin failures++; $display("FAIL drop_then_issue got=%b/%h exp=1/00000088", ok, addr); end
    step();
    done(5'd5);
  endtask

  task automatic test_rdy_freeze();
    bit ok, seen;
    apply_reset();
    rdy_in = 0;
    set_enq(5'd10, LOAD, 32'h4, 1, 32'h500, 0, 0, 0, 0);
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'd0) begin failures++; $display("FAIL freeze_enq got=%0d exp=0", dbg_count); end
    rdy_in = 1;
    set_enq(5'd10, LOAD, 32'h4, 1, 32'h500, 0, 0, 0, 0);
    step(); clear_inputs();
    rdy_in = 0;
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      if (have_ins === 1'b1) seen = 1;
      step();
    end
    checks++; if (seen !== 1'b0 || dbg_count !== 4'd1) begin failures++; $display("FAIL freeze_hold got=%b/%0d exp=0/1", seen, dbg_count); end
    rdy_in = 1;
    wait_issue(5, ok);
    checks++; if (!ok || addr !== 32'h504) begin failures++; $display("FAIL freeze_release got=%b/%h exp=1/00000504", ok, addr); end
    step();
    done(5'd10);
  endtask

  task automatic test_reset_busy();
    bit ok;
    apply_reset();
    set_enq(5'd11, LOAD, 32'h10, 1, 32'hDEAD0000, 0, 0, 0, 0);
    step(); clear_inputs();
    wait_issue(5, ok);
    step();
    rst_in = 0;
    #1;
    checks++; if (have_ins !== 1'b0 || addr !== 32'd0 || data !== 32'd0 || ins_id !== 5'd0) begin failures++; $display("FAIL rst_busy_out got=%b/%h/%h/%h exp=0/0/0/0", have_ins, addr, data, ins_id); end
    checks++; if (dbg_busy !== 1'b0 || dbg_count !== 4'd0 || full !== 1'b0) begin failures++; $display("FAIL rst_busy_state got=%b/%0d/%b exp=0/0/0", dbg_busy, dbg_count, full); end
    step();
    rst_in = 1;
    step();
    set_enq(5'd12, LOAD, 32'h1, 1, 32'h2, 0, 0, 0, 0);
    step(); clear_inputs();
    checks++; if (dbg_count !== 4'd1) begin failures++; $display("FAIL rst_accept got=%0d exp=1", dbg_count); end
    wait_issue(5, ok);
    checks++; if (!ok || ins_id !== 5'd12 || addr !== 32'h3) begin failures++; $display("FAIL rst_issue got=%b/%h/%h exp=1/0c/00000003", ok, ins_id, addr); end
    step();
    done(5'd12);
  endtask

  // Randomized in-order load stream against a queue model.
  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [4:0]  id_q[$];
    int          model_count, delay;
    bit          outstanding, do_pop, do_enq, acc;
    logic [4:0]  cur_id, next_id;
    logic [31:0] v, im;
    apply_reset();
    model_count = 0; outstanding = 0; next_id = 0; cur_id = 0; delay = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (have_ins === 1'b1) begin
        checks++;
        if (outstanding || exp_q.size() == 0) begin
          failures++; $display("FAIL rand_spurious got=1 exp=0 cyc=%0d", cyc);
        end else if (ins_id !== id_q[0] || addr !== exp_q[0]) begin
          failures++; $display("FAIL rand_issue got=%h/%h exp=%h/%h", ins_id, addr, id_q[0], exp_q[0]);
        end
        if (!outstanding && exp_q.size() != 0) begin
          outstanding = 1; cur_id = id_q[0]; delay = $urandom_range(0, 3);
        end
      end
      checks++;
      if (dbg_count !== 4'(model_count)) begin failures++; $display("FAIL rand_count got=%0d exp=%0d cyc=%0d", dbg_count, model_count, cyc); end
      clear_inputs();
      do_pop = 0;
      if (outstanding) begin
        if (delay == 0) do_pop = 1;
        else delay--;
      end
      mem_done = do_pop; mem_done_id = cur_id;
      do_enq = (cyc < 220) && ($urandom_range(0, 99) < 60);
      acc = do_enq && (model_count < DEPTH);
      v = $urandom; im = $urandom;
      if (do_enq) set_enq(next_id, LOAD, im, 1, v, 0, 0, 0, 0);
      step();
      if (acc) begin
        exp_q.push_back(v + im);
        id_q.push_back(next_id);
        next_id++;
      end
      if (do_pop) begin
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        outstanding = 0;
      end
      model_count = exp_q.size();
    end
    clear_inputs();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d exp=0", exp_q.size()); end
  endtask

  // Sequencer and final report
  initial begin
    clear_inputs();
    rdy_in = 1;
    rst_in = 0;
    test_reset();
    test_load();
    test_store_commit();
    test_full();
    test_cdb_bypass();
    test_flush();
    test_rdy_freeze();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
